// File: rtl/darkspi_slave_if.sv
// ============================================================================
// darkspi_slave_if : SPI pins plus TX/RX valid-ready ports of darkspi_slave
// Rev 1.0
// ============================================================================
`default_nettype none

interface darkspi_slave_if #(
  parameter int WIDTH = 8
) ();

  logic             spi_sck;
  logic             spi_csn;
  logic             spi_mosi;
  logic             spi_miso;
  logic             spi_miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             overrun;
  logic             busy;

  modport slave (
    input  spi_sck, spi_csn, spi_mosi, tx_data, tx_valid, rx_ready,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );

  modport master (
    output spi_sck, spi_csn, spi_mosi, tx_data, tx_valid, rx_ready,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );

endinterface

`default_nettype wire

// File: rtl/darkspi_slave.sv
// ============================================================================
// darkspi_slave : oversampled SPI mode-0 responder with RX/TX valid-ready ports
// Optional: define SPISLV_LOOPBACK_EN to echo the last received word when the
// TX buffer is empty at a word boundary.
// Rev 1.0
// ============================================================================
`default_nettype none

module darkspi_slave #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL  = WIDTH'(8'hFF),
  parameter int               SYNC  = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  darkspi_slave_if.slave   bus
);

  localparam int C_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [SYNC:0]      r_sck_sr;
  logic [SYNC:0]      r_csn_sr;
  logic [SYNC-1:0]    r_mosi_sr;
  logic [C_CNT_W-1:0] r_bitcnt;
  logic [WIDTH-1:0]   r_shift_rx;
  logic [WIDTH-1:0]   r_shift_tx;
  logic               r_miso;
  logic               r_oe;
  logic               r_busy;
  logic [WIDTH-1:0]   r_tx_buf;
  logic               r_tx_full;
  logic [WIDTH-1:0]   r_rx_data;
  logic               r_rx_valid;
  logic               r_overrun;

  logic               w_sck_rise;
  logic               w_sck_fall;
  logic               w_csn_fall;
  logic               w_csn_rise;
  logic               w_mosi;
  logic               w_boundary;
  logic               w_load;
  logic               w_tx_accept;
  logic               w_rx_accept;
  logic [WIDTH-1:0]   w_empty_reply;
  logic [WIDTH-1:0]   w_next_tx;

  // The top flop of each chain is the history bit used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sr  <= '0;
      r_csn_sr  <= '1;
      r_mosi_sr <= '0;
    end else begin
      r_sck_sr  <= {r_sck_sr[SYNC-1:0], bus.spi_sck};
      r_csn_sr  <= {r_csn_sr[SYNC-1:0], bus.spi_csn};
      r_mosi_sr <= {r_mosi_sr[SYNC-2:0], bus.spi_mosi};
    end
  end

  assign w_sck_rise  =  r_sck_sr[SYNC-1] & ~r_sck_sr[SYNC];
  assign w_sck_fall  = ~r_sck_sr[SYNC-1] &  r_sck_sr[SYNC];
  assign w_csn_fall  = ~r_csn_sr[SYNC-1] &  r_csn_sr[SYNC];
  assign w_csn_rise  =  r_csn_sr[SYNC-1] & ~r_csn_sr[SYNC];
  assign w_mosi      =  r_mosi_sr[SYNC-1];

  assign w_tx_accept = bus.tx_valid & ~r_tx_full;
  assign w_rx_accept = r_rx_valid & bus.rx_ready;

  assign w_boundary  = (r_state == ST_SHIFT) & ~w_csn_rise & w_sck_fall &
                       (r_bitcnt == C_CNT_W'(WIDTH));
  assign w_load      = ((r_state == ST_IDLE) & w_csn_fall) | w_boundary;

`ifdef SPISLV_LOOPBACK_EN
  assign w_empty_reply = r_shift_rx;
`else
  assign w_empty_reply = FILL;
`endif

  // CSN fall always replies FILL when empty; only word boundaries may echo.
  assign w_next_tx = r_tx_full  ? r_tx_buf      :
                     w_boundary ? w_empty_reply : FILL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
    end else if (w_load && r_tx_full) begin
      r_tx_full <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_buf  <= bus.tx_data;
      r_tx_full <= 1'b1;
    end
  end

  // Acceptance and a new word in the same cycle store the word without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_rx_accept) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      if (w_boundary) begin
        if (!r_rx_valid || w_rx_accept) begin
          r_rx_data  <= r_shift_rx;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift_rx <= '0;
      r_shift_tx <= '0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_csn_fall) begin
            r_state    <= ST_SHIFT;
            r_shift_tx <= w_next_tx;
            r_miso     <= w_next_tx[WIDTH-1];
            r_bitcnt   <= '0;
            r_oe       <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_csn_rise) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_miso   <= 1'b0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_sck_rise) begin
            r_shift_rx <= {r_shift_rx[WIDTH-2:0], w_mosi};
            r_bitcnt   <= r_bitcnt + 1'b1;
          end else if (w_sck_fall) begin
            if (w_boundary) begin
              r_shift_tx <= w_next_tx;
              r_miso     <= w_next_tx[WIDTH-1];
              r_bitcnt   <= '0;
            end else begin
              r_shift_tx <= {r_shift_tx[WIDTH-2:0], 1'b0};
              r_miso     <= r_shift_tx[WIDTH-2];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.spi_miso    = r_miso;
  assign bus.spi_miso_oe = r_oe;
  assign bus.busy        = r_busy;
  assign bus.tx_ready    = ~r_tx_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_darkspi_slave.sv
// Self-checking bench for darkspi_slave: vector table, directed corner cases
// and randomized transfers against a word-level reference model.
`default_nettype none

module tb_darkspi_slave;

  localparam int         H    = 8;
  localparam int         SYNC = 2;
  localparam logic [7:0] FILL = 8'hFF;
`ifdef SPISLV_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  darkspi_slave_if #(.WIDTH(8)) bus ();

  darkspi_slave #(.WIDTH(8), .FILL(FILL), .SYNC(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [7:0] tx_q[$];
  logic       m_rx_valid = 1'b0;
  logic [7:0] m_rx = '0;
  logic       m_ovr = 1'b0;

  typedef struct {
    logic       pre_en;
    logic [7:0] pre;
    logic [7:0] mosi;
    logic [7:0] miso;
    logic [7:0] rx;
    logic       ovr;
    logic       acc;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csn_high();
    clks(H);
    bus.spi_csn = 1'b1;
    clks(H);
  endtask

  // Mode 0: data set up while SCK low, MISO sampled just before the rising edge.
  task automatic xfer_bits(input logic [7:0] w, input int nbits, input bit acc,
                           output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = w[7-i];
      clks(H);
      got[7-i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      clks(H);
      bus.spi_sck = 1'b0;
      if (acc && i == nbits - 1) begin
        clks(SYNC);
        bus.rx_ready = 1'b1;
        clks(1);
        bus.rx_ready = 1'b0;
      end
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    chk("tx_ready_before_push", bus.tx_ready, 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    clks(1);
    bus.tx_valid = 1'b0;
    clks(1);
    chk("tx_ready_after_push", bus.tx_ready, 0);
  endtask

  task automatic accept_rx();
    bus.rx_ready = 1'b1;
    clks(1);
    bus.rx_ready = 1'b0;
    clks(1);
    chk("rx_valid_after_accept", bus.rx_valid, 0);
    chk("overrun_after_accept", bus.overrun, 0);
  endtask

  task automatic single_word(input logic [7:0] w, output logic [7:0] got);
    bus.spi_csn = 1'b0;
    xfer_bits(w, 8, 1'b0, got);
    csn_high();
  endtask

  task automatic rand_xfer(input int n);
    logic [7:0] words[3];
    logic [7:0] got, exp;
    for (int k = 0; k < 3; k++) words[k] = 8'($urandom);
    bus.spi_csn = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (tx_q.size() > 0) exp = tx_q.pop_front();
      else if (k > 0 && LOOP) exp = words[k-1];
      else exp = FILL;
      xfer_bits(words[k], 8, 1'b0, got);
      chk($sformatf("rand_miso_w%0d", k), got, exp);
      if (m_rx_valid) m_ovr = 1'b1;
      else begin
        m_rx_valid = 1'b1;
        m_rx = words[k];
      end
    end
    csn_high();
    chk("rand_rx_valid", bus.rx_valid, m_rx_valid);
    if (m_rx_valid) chk("rand_rx_data", bus.rx_data, m_rx);
    chk("rand_overrun", bus.overrun, m_ovr);
    chk("rand_tx_ready", bus.tx_ready, tx_q.size() == 0);
    chk("rand_busy", bus.busy, 0);
  endtask

  initial begin
    logic [7:0] got, d;

    bus.spi_sck = 1'b0; bus.spi_csn = 1'b1; bus.spi_mosi = 1'b0;
    bus.tx_data = '0;   bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;

    tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 8'h96, 8'hFF, 8'h96, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'hC3, 8'h12, 8'hC3, 8'hFF, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b1};

    clks(3);
    chk("reset_miso", bus.spi_miso, 0);
    chk("reset_oe", bus.spi_miso_oe, 0);
    chk("reset_tx_ready", bus.tx_ready, 1);
    chk("reset_rx_data", bus.rx_data, 0);
    chk("reset_rx_valid", bus.rx_valid, 0);
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    clks(4);

    for (int v = 0; v < 5; v++) begin
      if (tbl[v].pre_en) push_tx(tbl[v].pre);
      single_word(tbl[v].mosi, got);
      chk($sformatf("tbl%0d_miso", v), got, tbl[v].miso);
      chk($sformatf("tbl%0d_rx_valid", v), bus.rx_valid, 1);
      chk($sformatf("tbl%0d_rx_data", v), bus.rx_data, tbl[v].rx);
      chk($sformatf("tbl%0d_overrun", v), bus.overrun, tbl[v].ovr);
      chk($sformatf("tbl%0d_tx_ready", v), bus.tx_ready, 1);
      if (tbl[v].acc) accept_rx();
    end

    // Two words under one CSN with an empty buffer.
    bus.spi_csn = 1'b0;
    xfer_bits(8'h11, 8, 1'b0, got);
    chk("b2b_miso0", got, FILL);
    xfer_bits(8'h22, 8, 1'b0, got);
    chk("b2b_miso1", got, LOOP ? 8'h11 : FILL);
    csn_high();
    chk("b2b_rx_data", bus.rx_data, 8'h11);
    chk("b2b_rx_valid", bus.rx_valid, 1);
    chk("b2b_overrun", bus.overrun, 1);
    accept_rx();

    // Partial word discarded on CSN rise.
    bus.spi_csn = 1'b0;
    xfer_bits(8'hF0, 5, 1'b0, got);
    clks(H);
    chk("partial_busy", bus.busy, 1);
    chk("partial_oe", bus.spi_miso_oe, 1);
    bus.spi_csn = 1'b1;
    clks(H);
    chk("partial_rx_valid", bus.rx_valid, 0);
    chk("partial_oe_off", bus.spi_miso_oe, 0);
    chk("partial_miso_off", bus.spi_miso, 0);
    single_word(8'h81, got);
    chk("after_partial_rx", bus.rx_data, 8'h81);
    chk("after_partial_valid", bus.rx_valid, 1);

    // Acceptance lands in the boundary cycle of the second word.
    bus.spi_csn = 1'b0;
    xfer_bits(8'h4B, 8, 1'b0, got);
    xfer_bits(8'hB4, 8, 1'b1, got);
    csn_high();
    chk("acc_bnd_rx_data", bus.rx_data, 8'hB4);
    chk("acc_bnd_rx_valid", bus.rx_valid, 1);
    chk("acc_bnd_overrun", bus.overrun, 0);
    accept_rx();

    // Asynchronous reset mid-transfer with a word pending and TX buffer full.
    single_word(8'h77, got);
    push_tx(8'h3C);
    bus.spi_csn = 1'b0;
    xfer_bits(8'h99, 4, 1'b0, got);
    clks(2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_miso", bus.spi_miso, 0);
    chk("arst_oe", bus.spi_miso_oe, 0);
    chk("arst_tx_ready", bus.tx_ready, 1);
    chk("arst_rx_data", bus.rx_data, 0);
    chk("arst_rx_valid", bus.rx_valid, 0);
    chk("arst_overrun", bus.overrun, 0);
    chk("arst_busy", bus.busy, 0);
    bus.spi_csn = 1'b1;
    bus.spi_sck = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(4);
    single_word(8'h5A, got);
    chk("post_rst_miso", got, FILL);
    chk("post_rst_rx", bus.rx_data, 8'h5A);
    accept_rx();

    // SCK activity with CSN high is ignored.
    for (int i = 0; i < 8; i++) begin
      bus.spi_mosi = 1'($urandom);
      bus.spi_sck = 1'b1;
      clks(H);
      bus.spi_sck = 1'b0;
      clks(H);
    end
    chk("idle_sck_rx_valid", bus.rx_valid, 0);
    chk("idle_sck_oe", bus.spi_miso_oe, 0);
    chk("idle_sck_busy", bus.busy, 0);
    single_word(8'h6E, got);
    chk("idle_sck_next_rx", bus.rx_data, 8'h6E);
    chk("idle_sck_next_miso", got, FILL);
    accept_rx();

    m_rx_valid = 1'b0;
    m_ovr = 1'b0;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        push_tx(d);
        tx_q.push_back(d);
      end
      rand_xfer(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 1) == 1) begin
        accept_rx();
        m_rx_valid = 1'b0;
        m_ovr = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

`default_nettype wire
